pattern_scan: RTL and testbench

PATTERN_SCAN -- requirements
Module: pattern_scan

---
 rtl/pattern_scan.sv | 165 ++++++++++++++++
 tb/tb_pattern_scan.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan.sv
// pattern_scan: serial bit-stream pattern detector.
//
// dataIn, dataClk and dataEn come from an asynchronous source. All three are
// synchronised into clk. dataClk is then deglitched. Each filtered rising edge
// of dataClk, taken while dataEn is low, shifts one bit into a PAT_LEN-bit
// sliding window. When the window holds PATTERN, the block reports a hit.
//
// Ports
//   clk        system clock; all logic updates on its rising edge
//   rst        asynchronous, active-high reset
//   dataIn     serial data (asynchronous)
//   dataClk    serial bit clock (asynchronous); data is taken on its filtered rise
//   dataEn     capture enable, active low (asynchronous); 1 clears the window
//   matched    pattern seen: latched when STICKY=1, live window compare when 0
//   matchPulse one-clk pulse per detected occurrence
//   matchCount saturating count of occurrences
//   fillCount  number of valid bits in the window, saturates at PAT_LEN
//   ledR/G/B   !matched, matched, synchronised dataIn
module pattern_scan #(
  parameter int unsigned          PAT_LEN       = 64,
  parameter logic [PAT_LEN-1:0]   PATTERN       = 64'h574AB5DEED517984,
  parameter int unsigned          SYNC_STAGES   = 2,
  parameter int unsigned          STABLE_CYCLES = 4,
  parameter int unsigned          STICKY        = 1,
  parameter int unsigned          COUNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dataIn,
  input  logic                         dataClk,
  input  logic                         dataEn,
  output logic                         matched,
  output logic                         matchPulse,
  output logic [COUNT_W-1:0]           matchCount,
  output logic [$clog2(PAT_LEN+1)-1:0] fillCount,
  output logic                         ledR,
  output logic                         ledG,
  output logic                         ledB
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
  localparam int unsigned FCNT_W = $clog2(STABLE_CYCLES + 1);

  // Synchronisers. The last stage of each chain is the synchronised signal.
  logic [SYNC_STAGES-1:0] sin_q, sclk_q, sen_q;
  // After reset this chain fills with ones. It marks when the synchronisers
  // hold real input values instead of their reset zeros.
  logic [SYNC_STAGES-1:0] vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_q  <= '0;
      sclk_q <= '0;
      sen_q  <= '0;
      vld_q  <= '0;
    end else begin
      sin_q  <= {sin_q[SYNC_STAGES-2:0], dataIn};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], dataClk};
      sen_q  <= {sen_q[SYNC_STAGES-2:0], dataEn};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  logic s_in, s_clk, s_en, s_vld;
  assign s_in  = sin_q[SYNC_STAGES-1];
  assign s_clk = sclk_q[SYNC_STAGES-1];
  assign s_en  = sen_q[SYNC_STAGES-1];
  assign s_vld = vld_q[SYNC_STAGES-1];

  // dataClk filter state and registers.
  logic              flevel_q, flevel_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              flip;
  // armed_q is set once a settled low level of dataClk has been seen after reset.
  // Without it, a dataClk that is already high at reset release would look
  // like a fresh rise.
  logic              armed_q, armed_d;
  logic [PAT_LEN-1:0] window_q, window_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               shift, shift_q;
  logic               cmp, hit;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               sticky_q, sticky_d;

  always_comb begin
    fcnt_d   = fcnt_q;
    flevel_d = flevel_q;
    flip     = 1'b0;
    if (s_clk != flevel_q) begin
      if (fcnt_q == FCNT_W'(STABLE_CYCLES - 1)) begin
        flip     = 1'b1;
        flevel_d = s_clk;
        fcnt_d   = '0;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end else begin
      fcnt_d = '0;
    end
  end

  assign armed_d = armed_q | (s_vld & ~s_clk & ~flevel_q);
  assign shift   = flip & s_clk & ~s_en & armed_q;

  // The enable clear takes priority over a shift in the same cycle.
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (s_en) begin
      window_d = '0;
      fill_d   = '0;
    end else if (shift) begin
      window_d = {s_in, window_q[PAT_LEN-1:1]};
      if (fill_q != FILL_W'(PAT_LEN)) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // Compare uses the registered window, so a hit is seen one cycle after its shift.
  assign cmp = (fill_q == FILL_W'(PAT_LEN)) && (window_q == PATTERN);
  assign hit = shift_q & cmp;

  always_comb begin
    count_d  = count_q;
    sticky_d = sticky_q;
    if (hit) begin
      sticky_d = 1'b1;
      if (count_q != {COUNT_W{1'b1}}) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flevel_q <= 1'b0;
      fcnt_q   <= '0;
      armed_q  <= 1'b0;
      window_q <= '0;
      fill_q   <= '0;
      shift_q  <= 1'b0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      flevel_q <= flevel_d;
      fcnt_q   <= fcnt_d;
      armed_q  <= armed_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      shift_q  <= shift;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  assign matched    = (STICKY != 0) ? sticky_q : cmp;
  assign matchPulse = hit;
  assign matchCount = count_q;
  assign fillCount  = fill_q;
  assign ledR       = ~matched;
  assign ledG       = matched;
  assign ledB       = s_in;

endmodule

// File: tb/tb_pattern_scan.sv
// Self-checking bench for pattern_scan. Three instances share one stimulus:
//   inst 0: PATTERN 8'hA5, sticky
//   inst 1: PATTERN 8'h55, sticky
//   inst 2: PATTERN 8'hA5, non-sticky
// The reference model keeps the last received bits in a queue. It finds hits
// by comparing that queue with each pattern bit by bit.
module tb_pattern_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dataIn = 1'b0, dataClk = 1'b0, dataEn = 1'b0;

  logic [2:0] m_w, p_w, ledr_w, ledg_w, ledb_w;
  logic [15:0] cnt_w [3];
  logic [3:0]  fill_w [3];

  always #5 clk = ~clk;

  pattern_scan #(.PAT_LEN(8), .PATTERN(8'hA5), .STICKY(1)) u_a5 (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataClk(dataClk), .dataEn(dataEn),
    .matched(m_w[0]), .matchPulse(p_w[0]), .matchCount(cnt_w[0]), .fillCount(fill_w[0]),
    .ledR(ledr_w[0]), .ledG(ledg_w[0]), .ledB(ledb_w[0]));

  pattern_scan #(.PAT_LEN(8), .PATTERN(8'h55), .STICKY(1)) u_55 (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataClk(dataClk), .dataEn(dataEn),
    .matched(m_w[1]), .matchPulse(p_w[1]), .matchCount(cnt_w[1]), .fillCount(fill_w[1]),
    .ledR(ledr_w[1]), .ledG(ledg_w[1]), .ledB(ledb_w[1]));

  pattern_scan #(.PAT_LEN(8), .PATTERN(8'hA5), .STICKY(0)) u_ns (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataClk(dataClk), .dataEn(dataEn),
    .matched(m_w[2]), .matchPulse(p_w[2]), .matchCount(cnt_w[2]), .fillCount(fill_w[2]),
    .ledR(ledr_w[2]), .ledG(ledg_w[2]), .ledB(ledb_w[2]));

  // Pulse counters are never reset, so exp_pulses is cumulative as well.
  int pulses [3] = '{0, 0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (p_w[i]) pulses[i] <= pulses[i] + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [7:0] pat_m [3];
  bit         sticky_m [3];
  bit         q [$];
  int         exp_cnt [3];
  bit         exp_stk [3];
  int         exp_pulses [3] = '{0, 0, 0};

  function automatic bit window_is(int i);
    if (q.size() != 8) return 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (q[k] != pat_m[i][k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit exp_m(int i);
    return sticky_m[i] ? exp_stk[i] : window_is(i);
  endfunction

  task automatic model_shift(input bit b);
    q.push_back(b);
    if (q.size() > 8) void'(q.pop_front());
    for (int i = 0; i < 3; i++) begin
      if (window_is(i)) begin
        exp_cnt[i]++;
        exp_pulses[i]++;
        exp_stk[i] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_cnt[i] = 0;
      exp_stk[i] = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input int lo, input int hi);
    dataIn = b;
    tick(lo);
    dataClk = 1'b1;
    tick(hi);
    dataClk = 1'b0;
    model_shift(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(5);
  endtask

  task automatic test_reset();
    dataIn = 1'b0;
    dataClk = 1'b0;
    dataEn = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (m_w[i] !== 1'b0 || p_w[i] !== 1'b0 || cnt_w[i] !== 16'd0 || fill_w[i] !== 4'd0) begin
        fails++;
        $display("FAIL reset_outputs inst=%0d got m=%b p=%b cnt=%0d fill=%0d exp all 0",
                 i, m_w[i], p_w[i], cnt_w[i], fill_w[i]);
      end
      tests++;
      if (ledr_w[i] !== 1'b1 || ledg_w[i] !== 1'b0 || ledb_w[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_leds inst=%0d got rgb=%b%b%b exp 100",
                 i, ledr_w[i], ledg_w[i], ledb_w[i]);
      end
    end
  endtask

  task automatic test_single_match();
    logic [7:0] pv;
    pv = 8'hA5;
    do_reset();
    for (int k = 0; k < 8; k++) send_bit(pv[k], 8, 10);
    tick(2);
    tests++;
    if (cnt_w[0] !== 16'd1 || m_w[0] !== 1'b1 || pulses[0] !== exp_pulses[0]) begin
      fails++;
      $display("FAIL a5_match got cnt=%0d m=%b pulses=%0d exp cnt=1 m=1 pulses=%0d",
               cnt_w[0], m_w[0], pulses[0], exp_pulses[0]);
    end
    tests++;
    if (ledg_w[0] !== 1'b1 || ledr_w[0] !== 1'b0) begin
      fails++;
      $display("FAIL a5_leds got g=%b r=%b exp g=1 r=0", ledg_w[0], ledr_w[0]);
    end
    tests++;
    if (cnt_w[1] !== 16'd0 || m_w[1] !== 1'b0) begin
      fails++;
      $display("FAIL a5_other got cnt=%0d m=%b exp 0 0", cnt_w[1], m_w[1]);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send_bit(((k % 2) == 0), 7 + (k % 3), 10);
      tests++;
      if (cnt_w[1] !== 16'(exp_cnt[1]) || fill_w[1] !== 4'(q.size())) begin
        fails++;
        $display("FAIL overlap_bit%0d got cnt=%0d fill=%0d exp cnt=%0d fill=%0d",
                 k + 1, cnt_w[1], fill_w[1], exp_cnt[1], q.size());
      end
    end
    tests++;
    if (cnt_w[1] !== 16'd2 || pulses[1] !== exp_pulses[1]) begin
      fails++;
      $display("FAIL overlap_total got cnt=%0d pulses=%0d exp cnt=2 pulses=%0d",
               cnt_w[1], pulses[1], exp_pulses[1]);
    end
  endtask

  task automatic test_filter();
    int lat;
    do_reset();
    send_bit(1'b1, 8, 10);
    tick(10);
    // The 2-cycle glitch is shorter than STABLE_CYCLES, so no bit is shifted.
    dataClk = 1'b1;
    tick(2);
    dataClk = 1'b0;
    tick(12);
    tests++;
    if (fill_w[0] !== 4'd1) begin
      fails++;
      $display("FAIL glitch_noshift got fill=%0d exp 1", fill_w[0]);
    end
    // The 6-cycle pulse must shift once. Its latency is SYNC_STAGES + STABLE_CYCLES,
    // within one cycle either way.
    lat = 0;
    dataClk = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      if (lat == 0 && fill_w[0] !== 4'd1) lat = k;
    end
    dataClk = 1'b0;
    model_shift(dataIn);
    tick(12);
    tests++;
    if (fill_w[0] !== 4'd2) begin
      fail_line_fill: begin
        fails++;
        $display("FAIL pulse6_shift got fill=%0d exp 2", fill_w[0]);
      end
    end
    tests++;
    if (lat < 5 || lat > 7) begin
      fails++;
      $display("FAIL shift_latency got %0d cycles exp 5..7", lat);
    end
  endtask

  task automatic test_nonsticky();
    logic [7:0] pv;
    pv = 8'hA5;
    do_reset();
    for (int k = 0; k < 7; k++) send_bit(pv[k], 8, 10);
    tests++;
    if (m_w[2] !== 1'b0) begin
      fails++;
      $display("FAIL nonsticky_before got m=%b exp 0", m_w[2]);
    end
    send_bit(pv[7], 8, 10);
    tests++;
    if (m_w[2] !== 1'b1 || cnt_w[2] !== 16'd1) begin
      fails++;
      $display("FAIL nonsticky_hit got m=%b cnt=%0d exp m=1 cnt=1", m_w[2], cnt_w[2]);
    end
    send_bit(1'b1, 8, 10);
    tests++;
    if (m_w[2] !== 1'b0 || cnt_w[2] !== 16'd1 || m_w[0] !== 1'b1) begin
      fails++;
      $display("FAIL nonsticky_after got m=%b cnt=%0d sticky_m=%b exp m=0 cnt=1 sticky_m=1",
               m_w[2], cnt_w[2], m_w[0]);
    end
  endtask

  task automatic test_enable();
    logic [7:0] pv;
    int base;
    pv = 8'hA5;
    do_reset();
    for (int k = 0; k < 5; k++) send_bit(pv[k], 8, 10);
    dataEn = 1'b1;
    q.delete();
    tick(4);
    tests++;
    if (fill_w[0] !== 4'd0) begin
      fails++;
      $display("FAIL enable_clear got fill=%0d exp 0", fill_w[0]);
    end
    // A bit clocked while capture is disabled must not shift.
    send_bit(1'b1, 4, 10);
    void'(q.pop_back());
    tests++;
    if (fill_w[0] !== 4'd0) begin
      fails++;
      $display("FAIL enable_hold got fill=%0d exp 0", fill_w[0]);
    end
    dataEn = 1'b0;
    tick(3);
    base = pulses[0];
    for (int k = 0; k < 8; k++) send_bit(pv[k], 8, 10);
    tick(2);
    tests++;
    if (cnt_w[0] !== 16'd1 || pulses[0] - base !== 1) begin
      fails++;
      $display("FAIL enable_hit got cnt=%0d pulses=%0d exp cnt=1 pulses=1",
               cnt_w[0], pulses[0] - base);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pv;
    pv = 8'hA5;
    do_reset();
    for (int k = 0; k < 7; k++) send_bit(pv[k], 8, 10);
    rst = 1'b1;
    #1;
    tests++;
    if (fill_w[0] !== 4'd0) begin
      fails++;
      $display("FAIL async_reset got fill=%0d exp 0", fill_w[0]);
    end
    // If dataClk is already high when reset releases, nothing is shifted.
    dataClk = 1'b1;
    dataIn = 1'b1;
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(15);
    tests++;
    if (fill_w[0] !== 4'd0) begin
      fails++;
      $display("FAIL high_at_release got fill=%0d exp 0", fill_w[0]);
    end
    dataClk = 1'b0;
    tick(10);
    send_bit(pv[7], 8, 10);
    tick(3);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (cnt_w[i] !== 16'd0 || m_w[i] !== 1'b0 || p_w[i] !== 1'b0 ||
          fill_w[i] !== 4'(q.size()) || pulses[i] !== exp_pulses[i]) begin
        fails++;
        $display("FAIL reset_mid inst=%0d got cnt=%0d m=%b fill=%0d pulses=%0d exp 0 0 %0d %0d",
                 i, cnt_w[i], m_w[i], fill_w[i], pulses[i], q.size(), exp_pulses[i]);
      end
      tests++;
      if (ledr_w[i] !== 1'b1 || ledg_w[i] !== 1'b0 || ledb_w[i] !== dataIn) begin
        fails++;
        $display("FAIL reset_mid_leds inst=%0d got rgb=%b%b%b exp 10%b",
                 i, ledr_w[i], ledg_w[i], ledb_w[i], dataIn);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] pv;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        dataEn = 1'b1;
        q.delete();
        tick($urandom_range(3, 6));
        dataEn = 1'b0;
        tick(3);
      end else if (r < 4) begin
        pv = pat_m[$urandom_range(0, 1)];
        for (int k = 0; k < 8; k++)
          send_bit(pv[k], $urandom_range(7, 12), $urandom_range(9, 14));
      end else begin
        send_bit(1'($urandom_range(0, 1)), $urandom_range(7, 12), $urandom_range(9, 14));
      end
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (cnt_w[i] !== 16'(exp_cnt[i]) || m_w[i] !== exp_m(i) ||
            fill_w[i] !== 4'(q.size()) || pulses[i] !== exp_pulses[i]) begin
          fails++;
          $display("FAIL random step=%0d inst=%0d got cnt=%0d m=%b fill=%0d pulses=%0d exp %0d %b %0d %0d",
                   n, i, cnt_w[i], m_w[i], fill_w[i], pulses[i],
                   exp_cnt[i], exp_m(i), q.size(), exp_pulses[i]);
        end
      end
    end
  endtask

  initial begin
    pat_m[0] = 8'hA5;
    pat_m[1] = 8'h55;
    pat_m[2] = 8'hA5;
    sticky_m[0] = 1'b1;
    sticky_m[1] = 1'b1;
    sticky_m[2] = 1'b0;
    model_reset();
    test_reset();
    test_single_match();
    test_overlap();
    test_filter();
    test_nonsticky();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
